// File: rtl/pipe_ctrl_pkg.sv
// Shared types and field positions for the pipeline stall/flush sequencer.
// Purely declarative: no logic, no latency, no flow control.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_e;

    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is a source of the instruction in ID.
// Combinational, zero latency; no flow control of its own.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic [31:0] ifid_instr_i,
    output logic        lu_o
);

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_unused;

    assign w_rs     = ifid_instr_i[RS_HI:RS_LO];
    assign w_rt     = ifid_instr_i[RT_HI:RT_LO];
    assign w_unused = ^{ifid_instr_i[31:26], ifid_instr_i[15:0]};

    // $0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign lu_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == w_rs) || (idex_rt_i == w_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Prioritised stall/flush/bubble control for the 5-stage pipeline; enables are combinational (0-cycle).
// Memory wait freezes every stage; load-use holds PC and IF/ID for one cycle; redirects flush IF/ID.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = CNT_W_DEF
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [31:0]      ifid_instr_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o,
    output logic [1:0]       state_o
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  STALL_MAX = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              r_err;

    logic w_lu;
    logic w_mem_hold;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_exmem_write;
    logic w_memwb_write;

    load_use_detect u_load_use_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_instr_i   (ifid_instr_i),
        .lu_o           (w_lu)
    );

    // Once waiting, only the ack matters; the request line is not re-qualified.
    assign w_mem_hold = (r_state == MEM_WAIT) ? !dmem_ack_i
                                              : (dmem_req_i && !dmem_ack_i);
    assign w_wait_inc = r_wait_cnt + 1'b1;

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_write = 1'b1;
        w_memwb_write = 1'b1;
        w_state_nxt   = RUN;
        if (w_mem_hold) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_write = 1'b0;
            w_state_nxt   = MEM_WAIT;
        end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (branch_taken_i || jump_i) begin
            w_ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_pc_write && (r_stall_cnt != STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // The count is held at zero in RUN, so every MEM_WAIT episode starts fresh.
            if (r_state == RUN) begin
                r_wait_cnt <= '0;
            end else if (w_mem_hold && (r_wait_cnt != WAIT_MAX)) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == WAIT_MAX) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign pc_write_o    = rst_i && w_pc_write;
    assign ifid_write_o  = rst_i && w_ifid_write;
    assign ifid_flush_o  = rst_i && w_ifid_flush;
    assign idex_bubble_o = rst_i && w_idex_bubble;
    assign exmem_write_o = rst_i && w_exmem_write;
    assign memwb_write_o = rst_i && w_memwb_write;
    assign stall_cnt_o   = rst_i ? r_stall_cnt : '0;
    assign err_o         = rst_i && r_err;
    assign state_o       = rst_i ? r_state : 2'b00;

endmodule
